// File: rtl/conv1_scheduler.sv
// Layer-1 window scheduler: walks every 3x3 window per filter, issues it to the
// XNOR/popcount datapath and writes back the in-order result bits. Optional perf counter: CONV1_SCHED_PERF_EN.
module conv1_scheduler #(
  parameter int IMG_DIM         = 28,
  parameter int KERNEL          = 3,
  parameter int NUM_FILTERS     = 8,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        win_valid,
  input  logic        win_ready,
  output logic [2:0]  win_filter,
  output logic [4:0]  win_row,
  output logic [4:0]  win_col,
  input  logic        res_valid,
  input  logic        res_bit,
  output logic        out_we,
  output logic [12:0] out_addr,
  output logic        out_bit,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] stall_cycles
);

  localparam int          OUT_DIM = IMG_DIM - KERNEL + 1;
  localparam int          TOTAL   = NUM_FILTERS * OUT_DIM * OUT_DIM;
  localparam logic [1:0]  MAX_O   = 2'(MAX_OUTSTANDING);
  localparam logic [4:0]  LAST_RC = 5'(OUT_DIM - 1);
  localparam logic [2:0]  LAST_F  = 3'(NUM_FILTERS - 1);
  localparam logic [12:0] TOTAL_W = 13'(TOTAL);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t      state;
  logic        armed;
  logic [1:0]  outstanding;
  logic [1:0]  out_next;
  logic [12:0] wr_idx;
  logic        xfer;
  logic        res_ok;
  logic        last_win;
  logic        start_ok;

  assign xfer     = win_valid && win_ready;
  // A result with nothing outstanding is a protocol error and is dropped.
  assign res_ok   = res_valid && (outstanding != 2'd0);
  assign last_win = (win_filter == LAST_F) && (win_row == LAST_RC) && (win_col == LAST_RC);
  // armed stays low for the first edge after reset release so a coincident start is ignored.
  assign start_ok = (state == IDLE) && start && armed;

  always_comb begin
    out_next = outstanding + {1'b0, xfer} - {1'b0, res_ok};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      armed       <= 1'b0;
      outstanding <= 2'd0;
      wr_idx      <= 13'd0;
      win_valid   <= 1'b0;
      win_filter  <= 3'd0;
      win_row     <= 5'd0;
      win_col     <= 5'd0;
      out_we      <= 1'b0;
      out_addr    <= 13'd0;
      out_bit     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      armed       <= 1'b1;
      done        <= 1'b0;
      outstanding <= out_next;
      out_we      <= res_ok;
      if (res_valid && (outstanding == 2'd0))
        err <= 1'b1;
      // Write order equals issue order, so the linear index is filter*676 + row*26 + col.
      if (res_ok) begin
        out_addr <= wr_idx;
        out_bit  <= res_bit;
        wr_idx   <= wr_idx + 13'd1;
      end
      case (state)
        IDLE: begin
          if (start_ok) begin
            state      <= RUN;
            busy       <= 1'b1;
            win_valid  <= 1'b1;
            win_filter <= 3'd0;
            win_row    <= 5'd0;
            win_col    <= 5'd0;
            wr_idx     <= 13'd0;
          end
        end
        RUN: begin
          if (xfer && !last_win) begin
            if (win_col == LAST_RC) begin
              win_col <= 5'd0;
              if (win_row == LAST_RC) begin
                win_row    <= 5'd0;
                win_filter <= win_filter + 3'd1;
              end else begin
                win_row <= win_row + 5'd1;
              end
            end else begin
              win_col <= win_col + 5'd1;
            end
          end
          if (xfer && last_win) begin
            win_valid <= 1'b0;
            state     <= DRAIN;
          end else begin
            // Holds valid while stalled (outstanding < limit then) and gates it at the limit.
            win_valid <= (out_next < MAX_O);
          end
        end
        DRAIN: begin
          if ((outstanding == 2'd0) && (wr_idx == TOTAL_W)) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CONV1_SCHED_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= 16'd0;
    end else if (start_ok) begin
      stall_cycles <= 16'd0;
    end else if ((state == RUN) &&
                 ((win_valid && !win_ready) || (!win_valid && (outstanding == MAX_O))) &&
                 (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`else
  assign stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_conv1_scheduler.sv
// Scoreboard bench for conv1_scheduler: a datapath responder feeds result bits,
// a monitor checks every feature-map write against the expected queue.
module tb_conv1_scheduler;

  localparam int OD    = 26;
  localparam int TOTAL = 8 * OD * OD;
  localparam int MAXO  = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        win_ready = 1'b0;
  logic        res_valid = 1'b0;
  logic        res_bit = 1'b0;
  logic        win_valid;
  logic [2:0]  win_filter;
  logic [4:0]  win_row;
  logic [4:0]  win_col;
  logic        out_we;
  logic [12:0] out_addr;
  logic        out_bit;
  logic        busy;
  logic        done;
  logic        err;
  logic [15:0] stall_cycles;

  conv1_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .win_valid(win_valid), .win_ready(win_ready),
    .win_filter(win_filter), .win_row(win_row), .win_col(win_col),
    .res_valid(res_valid), .res_bit(res_bit),
    .out_we(out_we), .out_addr(out_addr), .out_bit(out_bit),
    .busy(busy), .done(done), .err(err), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_addr_q[$];
  bit exp_bit_q[$];
  int wr_cnt = 0;
  int done_cnt = 0;
  bit mem [0:TOTAL-1];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every feature-map write.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_we) begin
        if (exp_addr_q.size() == 0) begin
          chk("unexpected_out_we", int'(out_we), 0);
        end else begin
          int a;
          bit b;
          a = exp_addr_q.pop_front();
          b = exp_bit_q.pop_front();
          chk("out_addr", int'(out_addr), a);
          chk("out_bit", int'(out_bit), int'(b));
          if (a >= 0 && a < TOTAL) mem[a] = out_bit;
          wr_cnt++;
          $display("write addr=%0d bit=%0d", out_addr, out_bit);
        end
      end
      if (!rst && done) done_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_win_filter"}, int'(win_filter), 0);
    chk({tag, "_win_row"}, int'(win_row), 0);
    chk({tag, "_win_col"}, int'(win_col), 0);
    chk({tag, "_out_we"}, int'(out_we), 0);
    chk({tag, "_out_addr"}, int'(out_addr), 0);
    chk({tag, "_out_bit"}, int'(out_bit), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_stall"}, int'(stall_cycles), 0);
  endtask

  // Runs one layer: rmode 0 = always ready with col[0] bits, 1 = ready 1-0-1 pattern, 2 = random.
  // abort_at > 0 returns (at a negedge) as soon as that many windows are accepted.
  task automatic run_layer(input int lat, input int rmode, input int abort_at, input int dup_at,
                           output int acc_out);
    int acc = 0;
    int res_n = 0;
    int cyc = 0;
    int tail = 0;
    int due_q[$];
    bit bit_q[$];
    bit prev_stall = 0;
    int pf = 0, pr = 0, pc = 0;
    wr_cnt = 0;
    done_cnt = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", int'(busy), 1);
    chk("win_valid_after_start", int'(win_valid), 1);
    while (cyc < 40000) begin
      int ost;
      start = 1'b0;
      ost = acc - res_n;
      res_valid = 1'b0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        bit b;
        b = bit_q.pop_front();
        void'(due_q.pop_front());
        res_valid = 1'b1;
        res_bit = b;
        exp_addr_q.push_back(res_n);
        exp_bit_q.push_back(b);
        res_n++;
      end
      if (prev_stall) begin
        chk("stall_valid_held", int'(win_valid), 1);
        chk("stall_coords_held", int'({win_filter, win_row, win_col}), (pf << 10) | (pr << 5) | pc);
      end
      case (rmode)
        0: win_ready = 1'b1;
        1: win_ready = (cyc % 3) != 1;
        default: win_ready = 1'($urandom_range(0, 1));
      endcase
      if (win_valid && win_ready) begin
        bit nb;
        chk("win_filter", int'(win_filter), acc / (OD * OD));
        chk("win_row", int'(win_row), (acc / OD) % OD);
        chk("win_col", int'(win_col), acc % OD);
        chk("outstanding_below_limit", int'(ost < MAXO), 1);
        nb = (rmode == 0) ? 1'((acc % OD) % 2) : 1'($urandom_range(0, 1));
        due_q.push_back(cyc + lat);
        bit_q.push_back(nb);
        $display("issue k=%0d f=%0d r=%0d c=%0d", acc, win_filter, win_row, win_col);
        acc++;
        if (acc == dup_at) start = 1'b1;
      end
      prev_stall = win_valid && !win_ready;
      pf = int'(win_filter);
      pr = int'(win_row);
      pc = int'(win_col);
      if (abort_at > 0 && acc >= abort_at) begin
        acc_out = acc;
        return;
      end
      if (done_cnt > 0) tail++;
      if (tail > 4) break;
      @(negedge clk);
      cyc++;
    end
    chk("run_completed_in_budget", int'(cyc < 40000), 1);
    win_ready = 1'b0;
    res_valid = 1'b0;
    acc_out = acc;
  endtask

  task automatic chk_complete(input int acc, input int exp_err);
    chk("accepted_windows", acc, TOTAL);
    chk("write_count", wr_cnt, TOTAL);
    chk("done_pulses", done_cnt, 1);
    chk("busy_after_done", int'(busy), 0);
    chk("err_after_run", int'(err), exp_err);
    chk("scoreboard_empty", exp_addr_q.size(), 0);
  endtask

  initial begin
    int acc;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Result strobe with nothing outstanding.
    res_valid = 1'b1;
    res_bit = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    chk("idle_res_err", int'(err), 1);
    chk("idle_res_no_we", int'(out_we), 0);
    @(negedge clk);

    // Full-rate run, result bit = col[0].
    run_layer(1, 0, 0, 0, acc);
    chk_complete(acc, 1);
    chk("mem_addr0", int'(mem[0]), 0);
    chk("mem_addr27", int'(mem[27]), 1);

    // Toggling ready, latency 4, duplicate start at window 100.
    run_layer(4, 1, 0, 100, acc);
    chk_complete(acc, 1);
`ifdef CONV1_SCHED_PERF_EN
    chk("stall_nonzero", int'(stall_cycles != 16'd0), 1);
`else
    chk("stall_tied_zero", int'(stall_cycles), 0);
`endif

    // Abort at window 3000.
    run_layer(2, 2, 3000, 0, acc);
    rst = 1'b1;
    res_valid = 1'b0;
    win_ready = 1'b0;
    #1;
    chk_zero("abort");
    exp_addr_q.delete();
    exp_bit_q.delete();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_at_release_ignored", int'(busy), 0);
    @(negedge clk);

    run_layer(2, 2, 0, 0, acc);
    chk_complete(acc, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv1_scheduler.md
Name: conv1_scheduler

Overview:
Sequences the layer-1 binary convolution of the MNIST BNN. After the FSM enters the layer-1 state, it walks every 3x3 window of the 28x28 pixel array for each of the 8 filters and issues window coordinates to the XNOR/popcount datapath through a valid/ready handshake. It collects the in-order result bits, writes each one to the layer-1 feature-map buffer, and reports completion to the FSM as layer_1_done.

Parameters:
IMG_DIM, 28, input image side length in pixels
KERNEL, 3, convolution window side
NUM_FILTERS, 8, number of layer-1 filters
MAX_OUTSTANDING, 2, maximum windows issued but not yet returned by the datapath (1..3)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse from the FSM to begin layer 1
win_valid  output  1  window request valid
win_ready  input  1  datapath accepts the request
win_filter  output  3  filter index of the request
win_row  output  5  top-left row of the window (0..OUT_DIM-1)
win_col  output  5  top-left column of the window (0..OUT_DIM-1)
res_valid  input  1  datapath result strobe; results return in issue order
res_bit  input  1  binarized activation for the oldest outstanding window
out_we  output  1  feature-map write enable
out_addr  output  13  feature-map address: filter*OUT_DIM^2 + row*OUT_DIM + col
out_bit  output  1  feature-map write data
busy  output  1  high from accepted start until done
done  output  1  single-cycle pulse; drives the FSM's layer_1_done
err  output  1  sticky protocol error flag
stall_cycles  output  16  perf counter (see Optional Feature)

Behaviour:
- OUT_DIM = IMG_DIM-KERNEL+1 = 26. Total windows = NUM_FILTERS*OUT_DIM^2 = 5408.
- Reset (async, rst=1): state IDLE. All outputs are 0: win_valid, win_* fields, out_we, out_addr, out_bit, busy, done, err, stall_cycles. All counters are cleared.
- States: IDLE -> RUN on start. RUN -> DRAIN once the last window is accepted. DRAIN -> DONE once the outstanding count reaches 0 and the last write has been issued. DONE -> IDLE after one cycle.
- Issue order: col is innermost, then row, then filter. win_valid asserts the cycle after start is accepted.
- Handshake: a transfer occurs when win_valid && win_ready. While win_valid is high without win_ready, win_* stay stable. win_valid drops when outstanding == MAX_OUTSTANDING and reasserts no earlier than the cycle after a result frees a slot.
- Outstanding count: +1 on a transfer, -1 on res_valid. Both in the same cycle leave it unchanged, and that transfer is legal even at the limit.
- Result path: a separate write-side counter (filter/row/col) tracks the oldest outstanding window. out_we=1 and out_addr/out_bit are registered, with 1-cycle latency after res_valid. The write counter advances on each result.
- done pulses in the DONE cycle, i.e. the cycle after the final out_we. busy is high from the cycle after start through the DONE cycle.
- start while busy is ignored. start in the same cycle as reset deassertion is ignored.
- res_valid with zero outstanding: no write, counters unchanged, err set. err clears only on reset.
- Reset mid-operation aborts immediately to IDLE. No done pulse is produced. Partial writes already made are left in the buffer.
- Wrap-around: col 25->0 increments row; row 25->0 increments filter; filter 7 at row/col 25 is the last window. No counter passes its bound.

Optional Feature:
Macro CONV1_SCHED_PERF_EN.
- Defined: stall_cycles counts cycles in RUN where win_valid=1 and win_ready=0, or where issue is blocked at MAX_OUTSTANDING. The count saturates at 16'hFFFF and clears on start and on reset.
- Not defined: the counter logic is omitted and stall_cycles is tied to 0.

Test Plan:
- win_ready=1, datapath returning res_valid 1 cycle after each accept, res_bit=col[0] -> 5408 writes; addr 0 has bit 0, addr 27 (row 1, col 1) has bit 1; a single done pulse; busy low afterwards.
- win_ready toggling 1-0-1, datapath latency 4 -> issue stalls at 2 outstanding; win_* stable during stalls; out_addr sequence strictly 0..5407; with PERF_EN, stall_cycles is nonzero.
- res_valid asserted in IDLE -> err=1, no out_we; a subsequent normal run completes and err stays 1.
- Second start pulse at window 100 -> ignored; total writes remain 5408 and only one done pulse occurs.
- Reset asserted at window 3000 -> all outputs 0 in the same cycle; a new start restarts from filter 0, row 0, col 0.
